// File: rtl/trena_sequenciador.sv
// Tape-measure sequencer: trigger sonar, latch result, stream N_CHARS chars to serial TX; optional auto repeat.
// Optional measurement timeout enabled by defining TRENA_SEQ_TIMEOUT_EN (default build: wait forever, erro tied 0).
module trena_sequenciador #(
    parameter int N_CHARS = 4,
    parameter int SEL_W   = 2,
    parameter int PERIODO = 50_000_000,
    parameter int TIMEOUT = 1_500_000
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             mensurar_i,
    input  logic             modo_auto_i,
    input  logic             pronto_medida_i,
    input  logic             pronto_tx_i,
    output logic             medir_o,
    output logic             registra_o,
    output logic             partida_tx_o,
    output logic [SEL_W-1:0] sel_char_o,
    output logic             fim_o,
    output logic             erro_o,
    output logic [3:0]       db_estado_o
);

    localparam logic [3:0] INICIAL        = 4'h0;
    localparam logic [3:0] DISPARA        = 4'h1;
    localparam logic [3:0] AGUARDA_MEDIDA = 4'h2;
    localparam logic [3:0] REGISTRA       = 4'h3;
    localparam logic [3:0] TRANSMITE      = 4'h4;
    localparam logic [3:0] AGUARDA_TX     = 4'h5;
    localparam logic [3:0] PROXIMO        = 4'h6;
    localparam logic [3:0] FINAL          = 4'h7;
    localparam logic [3:0] ERRO           = 4'h8;
    localparam logic [3:0] ESPERA_PERIODO = 4'h9;

    localparam int PER_W = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam logic [PER_W-1:0] PER_MAX  = PER_W'(PERIODO - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CHARS - 1);

    logic [3:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [PER_W-1:0] per_q, per_d;

`ifdef TRENA_SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] to_q, to_d;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        per_d   = per_q;
`ifdef TRENA_SEQ_TIMEOUT_EN
        to_d    = to_q;
`endif
        case (state_q)
            INICIAL: if (mensurar_i || modo_auto_i) state_d = DISPARA;
            DISPARA: begin
                sel_d   = '0;
`ifdef TRENA_SEQ_TIMEOUT_EN
                to_d    = '0;
`endif
                state_d = AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: begin
`ifdef TRENA_SEQ_TIMEOUT_EN
                // A measurement arriving on the expiry cycle still wins.
                if (pronto_medida_i)     state_d = REGISTRA;
                else if (to_q == TO_MAX) state_d = ERRO;
                else                     to_d    = to_q + 1'b1;
`else
                if (pronto_medida_i) state_d = REGISTRA;
`endif
            end
            REGISTRA:  state_d = TRANSMITE;
            TRANSMITE: state_d = AGUARDA_TX;
            AGUARDA_TX: begin
                if (pronto_tx_i) state_d = (sel_q == LAST_SEL) ? FINAL : PROXIMO;
            end
            PROXIMO: begin
                if (sel_q != LAST_SEL) sel_d = sel_q + 1'b1;
                state_d = TRANSMITE;
            end
            FINAL, ERRO: begin
                per_d   = '0;
                state_d = modo_auto_i ? ESPERA_PERIODO : INICIAL;
            end
            ESPERA_PERIODO: begin
                if (!modo_auto_i)          state_d = INICIAL;
                else if (per_q == PER_MAX) state_d = DISPARA;
                else                       per_d   = per_q + 1'b1;
            end
            default: state_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= INICIAL;
            sel_q   <= '0;
            per_q   <= '0;
`ifdef TRENA_SEQ_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            per_q   <= per_d;
`ifdef TRENA_SEQ_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    assign medir_o      = (state_q == DISPARA);
    assign registra_o   = (state_q == REGISTRA);
    assign partida_tx_o = (state_q == TRANSMITE);
    assign fim_o        = (state_q == FINAL);
    assign sel_char_o   = sel_q;
`ifdef TRENA_SEQ_TIMEOUT_EN
    assign erro_o       = (state_q == ERRO);
`else
    assign erro_o       = 1'b0;
`endif
    assign db_estado_o  = (state_q <= ESPERA_PERIODO) ? state_q : 4'hF;

endmodule

// File: tb/tb_trena_sequenciador.sv
// Scoreboard bench for trena_sequenciador: open-loop stimulus, expected pulse timeline queued by the reference model.
module tb_trena_sequenciador;
    localparam int NC  = 4;
    localparam int TO  = 20;
    localparam int PER = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1, mensurar = 1'b0, modo_auto = 1'b0, pm = 1'b0, ptx = 1'b0;
    logic       medir, registra, partida, fim, erro;
    logic [1:0] sel;
    logic [3:0] db;

    trena_sequenciador #(.N_CHARS(NC), .SEL_W(2), .PERIODO(PER), .TIMEOUT(TO)) dut (
        .clock_i(clk), .reset_i(reset), .mensurar_i(mensurar), .modo_auto_i(modo_auto),
        .pronto_medida_i(pm), .pronto_tx_i(ptx), .medir_o(medir), .registra_o(registra),
        .partida_tx_o(partida), .sel_char_o(sel), .fim_o(fim), .erro_o(erro), .db_estado_o(db)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    bit mon_en = 0;

    // kind: 0 medir, 1 registra, 2 partida_tx, 3 fim, 4 erro
    typedef struct { int c; int kind; int sel; } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_ev(input int c, input int kind, input int s);
        ev_t e;
        e.c = c; e.kind = kind; e.sel = s;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        logic [4:0] p;
        ev_t e;
        if (mon_en) begin
            p = {erro, fim, partida, registra, medir};
            for (int k = 0; k < 5; k++) begin
                if (p[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse_kind", k, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_kind", k, e.kind);
                        chk("pulse_cycle", cyc, e.c);
                        if (k == 2) chk("sel_char", int'(sel), e.sel);
                    end
                end
            end
        end
    end

    // Frame starting with medir at cycle m; measurement returns dmed cycles later.
    // stop_sel < NC: reset is applied while waiting on that character's TX.
    task automatic frame(input int m, input int dmed, input int stop_sel, output int f);
        int p_, t_, d_, pmc;
        pmc = m + dmed;
        f = -1;
        if (dmed >= 3) begin
            wait_until(m + 1); ptx = 1; tick(); ptx = 0;
        end
        wait_until(pmc);
        expect_ev(pmc + 1, 1, 0);
        expect_ev(pmc + 2, 2, 0);
        pm = 1; tick(); pm = 0;
        p_ = pmc + 2;
        for (int s = 0; s < NC; s++) begin
            d_ = $urandom_range(1, 6);
            if (s == stop_sel) begin
                wait_until(p_ + 1);
                reset = 1; tick(); reset = 0;
                chk("reset_mid_state", int'(db), 0);
                chk("reset_mid_sel", int'(sel), 0);
                ptx = 1; tick(); ptx = 0;
                chk("ignored_ptx_state", int'(db), 0);
                return;
            end
            if (d_ >= 3) begin
                wait_until(p_ + 1); pm = 1; tick(); pm = 0;
            end
            t_ = p_ + d_;
            wait_until(t_);
            if (s < NC - 1) begin
                p_ = t_ + 2;
                expect_ev(p_, 2, s + 1);
            end else begin
                f = t_ + 1;
                expect_ev(f, 3, 0);
            end
            ptx = 1; tick(); ptx = 0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, f, f2, dmed;
        repeat (3) tick();
        chk("reset_state", int'(db), 0);
        chk("reset_sel", int'(sel), 0);
        chk("reset_pulses", $countones({medir, registra, partida, fim, erro}), 0);
        reset = 0;
        mon_en = 1;
        tick();

        // Single-shot frames, including the response on the last legal cycle.
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 4)) tick();
            c = cyc;
            mensurar = 1; expect_ev(c + 1, 0, 0); tick(); mensurar = 0;
            dmed = (r == 0) ? 10 : (r == 1) ? TO : $urandom_range(1, TO);
            frame(c + 1, dmed, NC, f);
            wait_until(f + 1);
            chk("single_back_idle", int'(db), 0);
        end

        // No measurement response.
        tick();
        c = cyc;
        mensurar = 1; expect_ev(c + 1, 0, 0); tick(); mensurar = 0;
`ifdef TRENA_SEQ_TIMEOUT_EN
        expect_ev(c + 1 + TO + 1, 4, 0);
        wait_until(c + TO + 3);
        chk("after_timeout_state", int'(db), 0);
`else
        for (int k = 0; k < 10; k++) begin
            wait_until(c + 2 + 100 * k + $urandom_range(0, 99));
            chk("wait_forever_state", int'(db), 2);
        end
        wait_until(c + 1002);
        chk("wait_forever_final", int'(db), 2);
        reset = 1; tick(); reset = 0;
        chk("reset_from_wait", int'(db), 0);
`endif

        // mensurar held high: exactly one new frame per return to INICIAL.
        tick();
        c = cyc;
        mensurar = 1; expect_ev(c + 1, 0, 0); tick();
        frame(c + 1, $urandom_range(1, TO), NC, f);
        expect_ev(f + 2, 0, 0);
        wait_until(f + 2);
        mensurar = 0;
        frame(f + 2, $urandom_range(1, TO), NC, f2);
        wait_until(f2 + 1);
        chk("held_idle_1", int'(db), 0);
        tick();
        chk("held_idle_2", int'(db), 0);

        // Auto mode: fim to next medir is PERIODO+1 cycles.
        c = cyc;
        modo_auto = 1; expect_ev(c + 1, 0, 0); tick();
        frame(c + 1, $urandom_range(1, TO), NC, f);
        expect_ev(f + PER + 1, 0, 0);
        wait_until(f + 1);
        chk("auto_wait_state", int'(db), 9);
        frame(f + PER + 1, $urandom_range(1, TO), NC, f2);
        wait_until(f2 + 11);
        chk("auto_wait_state_2", int'(db), 9);
        modo_auto = 0; tick();
        chk("auto_drop_idle", int'(db), 0);

        // Reset while waiting on the third character.
        tick();
        c = cyc;
        mensurar = 1; expect_ev(c + 1, 0, 0); tick(); mensurar = 0;
        frame(c + 1, $urandom_range(1, TO), 2, f);
        repeat (10) tick();
        chk("final_idle", int'(db), 0);
        chk("pending_expectations", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
